hazard_unit: RTL

Stall and flush generator for the 5-stage core, the counterpart of the forwarding unit. The forwarding unit resolves hazards by bypassing results that already exist. This block covers the hazards that bypassing cannot resolve:
- load-use dependencies;
- pending destinations of the multi-cycle mul/div unit;
- write-back port contention;
- control-flow flushes.

It sits beside the ID/EX pipeline registers and drives the PC, IF/ID and ID/EX enables and bubbles.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_if.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 43 ++++
 rtl/hazard_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the hazard unit.
// Holds the FSM state encoding, the default mul/div latency and a saturating increment.
package hazard_unit_pkg;

    typedef enum logic {
        HZ_IDLE    = 1'b0,
        HZ_MD_BUSY = 1'b1
    } hz_state_e;

    localparam int MD_MAX_LAT_DEFAULT = 34;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: ID/EX/MEM/WB observations in, stall/flush controls out.
// The master drives pipeline status; the slave (hazard_unit) drives the controls.
interface hazard_unit_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_is_muldiv;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_regs_write;
    logic        ex_muldiv_issue;
    logic        md_done;
    logic [4:0]  md_rd;
    logic        wb_regs_write;
    logic        br_taken;
    logic        stall_pc;
    logic        stall_ifid;
    logic        bubble_idex;
    logic        flush_ifid;
    logic        md_wb_sel;
    logic        md_busy;
    logic        md_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_muldiv,
        output ex_rd, ex_mem_read, ex_regs_write, ex_muldiv_issue,
        output md_done, md_rd, wb_regs_write, br_taken,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid,
        input  md_wb_sel, md_busy, md_timeout, stall_cnt, md_stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_muldiv,
        input  ex_rd, ex_mem_read, ex_regs_write, ex_muldiv_issue,
        input  md_done, md_rd, wb_regs_write, br_taken,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid,
        output md_wb_sel, md_busy, md_timeout, stall_cnt, md_stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-destination scoreboard for the mul/div unit, x0 never tracked.
// Clear-then-set ordering lets a back-to-back issue to the same rd keep its bit.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rd_a,
    input  logic [4:0] rd_b,
    output logic       hit_a,
    output logic       hit_b
);

    logic [31:1] pend_q;
    logic [31:1] pend_d;
    logic [31:0] pend_v;

    assign pend_v = {pend_q, 1'b0};

    // Next pending vector: clear completing rd, then set issuing rd, flush wins.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            pend_d[i] = pend_q[i];
            if (clr_en && (clr_rd == 5'(i))) pend_d[i] = 1'b0;
            if (set_en && (set_rd == 5'(i))) pend_d[i] = 1'b1;
            if (flush) pend_d[i] = 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    // A result completing this cycle is bypassed, so it is not a hit.
    assign hit_a = pend_v[rd_a] & ~(clr_en & (clr_rd == rd_a));
    assign hit_b = pend_v[rd_b] & ~(clr_en & (clr_rd == rd_b));

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush generator for hazards bypassing cannot fix.
// Optional statistics counters are built with HAZARD_STATS_EN.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MD_MAX_LAT = MD_MAX_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);

    localparam int WD_W = $clog2(MD_MAX_LAT + 2);

    hz_state_e       state_q;
    logic [WD_W-1:0] wdog_q;
    logic            timeout_q;
    logic            wd_expire;
    logic            busy;
    logic            hit1;
    logic            hit2;
    logic            load_use;
    logic            sb_hit;
    logic            md_struct;
    logic            wb_conflict;
    logic            stall;
    logic            stall_pc;

    assign busy = (state_q == HZ_MD_BUSY);

    assign wd_expire = busy & ~hz.ex_muldiv_issue & ~hz.md_done
                     & (wdog_q == WD_W'(MD_MAX_LAT));

    hazard_scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .flush  (wd_expire),
        .set_en (hz.ex_muldiv_issue),
        .set_rd (hz.ex_rd),
        .clr_en (hz.md_done),
        .clr_rd (hz.md_rd),
        .rd_a   (hz.id_rs1),
        .rd_b   (hz.id_rs2),
        .hit_a  (hit1),
        .hit_b  (hit2)
    );

    // Mul/div tracking FSM with watchdog; an issue restarts the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HZ_IDLE;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (hz.ex_muldiv_issue) begin
            state_q <= HZ_MD_BUSY;
            wdog_q  <= '0;
        end else if (hz.md_done) begin
            state_q <= HZ_IDLE;
            wdog_q  <= '0;
        end else if (wd_expire) begin
            state_q   <= HZ_IDLE;
            wdog_q    <= '0;
            timeout_q <= 1'b1;
        end else if (busy) begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end

    assign load_use = hz.ex_mem_read & hz.ex_regs_write
                    & (hz.ex_rd != 5'd0)
                    & ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd))
                     | (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

    assign sb_hit      = (hz.id_rs1_used & hit1) | (hz.id_rs2_used & hit2);
    assign md_struct   = hz.id_is_muldiv & busy & ~hz.md_done;
    assign wb_conflict = hz.md_done & hz.wb_regs_write;
    assign stall       = load_use | sb_hit | md_struct | wb_conflict;
    assign stall_pc    = stall & ~hz.br_taken;

    assign hz.stall_pc    = stall_pc;
    assign hz.stall_ifid  = stall_pc;
    assign hz.bubble_idex = stall | hz.br_taken;
    assign hz.flush_ifid  = hz.br_taken;
    assign hz.md_wb_sel   = hz.md_done;
    assign hz.md_busy     = busy;
    assign hz.md_timeout  = timeout_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] md_stall_cnt_q;

    // Saturating stall statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            if (stall_pc)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (sb_hit | md_struct)
                md_stall_cnt_q <= sat_inc(md_stall_cnt_q);
        end
    end

    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.md_stall_cnt = md_stall_cnt_q;
`else
    assign hz.stall_cnt    = '0;
    assign hz.md_stall_cnt = '0;
`endif

endmodule
